// File: rtl/smem_fill_sequencer.sv
// Fills a contiguous range of SMEM rows through the HSI row writer. The pattern is either a constant or a word-incrementing ramp.
// State | meaning: IDLE accept cmd | WAIT_RDY wait writer ready | STROBE pulse start | DRAIN guard then wait done | FINISH report
module smem_fill_sequencer #(
    parameter int DW          = 512,
    parameter int DRAIN_GUARD = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [31:0]     cmd_first_row,
    input  logic [15:0]     cmd_row_count,
    input  logic            cmd_mode,
    input  logic [31:0]     cmd_seed,
    input  logic            abort,
    output logic            wr_start,
    output logic [31:0]     wr_row_index,
    output logic [DW-1:0]   wr_data3,
    output logic [DW-1:0]   wr_data2,
    output logic [DW-1:0]   wr_data1,
    output logic [DW-1:0]   wr_data0,
    input  logic            wr_ready,
    input  logic            wr_done,
    output logic            busy,
    output logic [15:0]     rows_issued,
    output logic            complete,
    output logic            aborted
);

    localparam int NW = 4 * (DW / 32);
    localparam int GW = $clog2(DRAIN_GUARD + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        STROBE   = 3'd2,
        DRAIN    = 3'd3,
        FINISH   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [31:0]     first_row_q;
    logic [31:0]     seed_q;
    logic [15:0]     row_count_q;
    logic [15:0]     k_q;
    logic            mode_q;
    logic            abort_seen_q;
    logic [GW-1:0]   guard_q;
    logic [4*DW-1:0] row_words;
    logic            accept;
    logic            last_row;

    assign accept   = cmd_valid && cmd_ready;
    assign last_row = ({1'b0, k_q} + 17'd1) == {1'b0, row_count_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (cmd_row_count == 16'd0) ? FINISH : WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (abort) begin
                    state_next = DRAIN;
                end else if (wr_ready) begin
                    state_next = STROBE;
                end
            end
            STROBE: begin
                state_next = (last_row || abort) ? DRAIN : WAIT_RDY;
            end
            DRAIN: begin
                if (guard_q == '0 && wr_done) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        wr_start  = 1'b0;
        busy      = 1'b0;
        complete  = 1'b0;
        aborted   = 1'b0;
        if (!reset) begin
            cmd_ready = (state == IDLE);
            wr_start  = (state == STROBE);
            busy      = (state != IDLE);
            complete  = (state == FINISH) && !abort_seen_q;
            aborted   = (state == FINISH) && abort_seen_q;
        end
    end

    // Word w of row k: constant seed, or seed + k*64 + w for the ramp.
    always_comb begin
        row_words = '0;
        for (int w = 0; w < NW; w++) begin
            row_words[w*32 +: 32] = mode_q ? (seed_q + {10'd0, k_q, 6'd0} + 32'(w)) : seed_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            first_row_q  <= '0;
            seed_q       <= '0;
            row_count_q  <= '0;
            k_q          <= '0;
            mode_q       <= 1'b0;
            abort_seen_q <= 1'b0;
            guard_q      <= '0;
            rows_issued  <= '0;
            wr_row_index <= '0;
            wr_data0     <= '0;
            wr_data1     <= '0;
            wr_data2     <= '0;
            wr_data3     <= '0;
        end else begin
            if (accept) begin
                first_row_q  <= cmd_first_row;
                seed_q       <= cmd_seed;
                row_count_q  <= cmd_row_count;
                mode_q       <= cmd_mode;
                k_q          <= '0;
                rows_issued  <= '0;
                abort_seen_q <= 1'b0;
            end
            // Row outputs only move here, so they hold while the writer streams.
            if (state == WAIT_RDY && !abort && wr_ready) begin
                wr_row_index <= first_row_q + {16'd0, k_q};
                wr_data0     <= row_words[DW-1:0];
                wr_data1     <= row_words[2*DW-1:DW];
                wr_data2     <= row_words[3*DW-1:2*DW];
                wr_data3     <= row_words[4*DW-1:3*DW];
            end
            if ((state == WAIT_RDY || state == STROBE) && abort) begin
                abort_seen_q <= 1'b1;
            end
            if (state == STROBE) begin
                rows_issued <= rows_issued + 16'd1;
                k_q         <= k_q + 16'd1;
            end
            if (state_next == DRAIN && state != DRAIN) begin
                guard_q <= GW'(DRAIN_GUARD);
            end else if (state == DRAIN && guard_q != '0) begin
                guard_q <= guard_q - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_smem_fill_sequencer.sv
// Bench for smem_fill_sequencer: a behavioural writer model plus a row-pattern reference model.
module tb_smem_fill_sequencer;

    localparam int DW = 512;
    localparam int G  = 16;
    localparam int NH = 20000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_first_row = '0;
    logic [15:0]   cmd_row_count = '0;
    logic          cmd_mode = 1'b0;
    logic [31:0]   cmd_seed = '0;
    logic          abort = 1'b0;
    logic          wr_start;
    logic [31:0]   wr_row_index;
    logic [DW-1:0] wr_data3, wr_data2, wr_data1, wr_data0;
    logic          wr_ready;
    logic          wr_done = 1'b1;
    logic          busy;
    logic [15:0]   rows_issued;
    logic          complete;
    logic          aborted;

    always #5 clk = ~clk;

    smem_fill_sequencer #(.DW(DW), .DRAIN_GUARD(G)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_first_row(cmd_first_row), .cmd_row_count(cmd_row_count), .cmd_mode(cmd_mode),
        .cmd_seed(cmd_seed), .abort(abort), .wr_start(wr_start), .wr_row_index(wr_row_index),
        .wr_data3(wr_data3), .wr_data2(wr_data2), .wr_data1(wr_data1), .wr_data0(wr_data0),
        .wr_ready(wr_ready), .wr_done(wr_done), .busy(busy), .rows_issued(rows_issued),
        .complete(complete), .aborted(aborted)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cnt = 0, complete_cnt = 0, aborted_cnt = 0;
    int last_start_cyc = 0, fin_cyc = 0, stab_viol = 0;
    int busy_len = 1;
    int wbusy = 0;
    logic stall = 1'b0;
    logic wr_ready_w = 1'b1;
    bit   done_hist [NH];
    logic [31:0]      cap_idx [$];
    logic [4*DW-1:0]  cap_data [$];
    logic [32+4*DW-1:0] prev_out = '0;
    logic [32+4*DW-1:0] cur_out;
    logic rst_prev = 1'b1;

    assign cur_out  = {wr_row_index, wr_data3, wr_data2, wr_data1, wr_data0};
    assign wr_ready = wr_ready_w & ~stall;

    // Monitor and writer model; cycle n's inputs are set here or by tasks just after this edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (wr_start) begin
                start_cnt++;
                last_start_cyc = cyc;
                cap_idx.push_back(wr_row_index);
                cap_data.push_back({wr_data3, wr_data2, wr_data1, wr_data0});
            end
            if (complete) begin complete_cnt++; fin_cyc = cyc; end
            if (aborted)  begin aborted_cnt++;  fin_cyc = cyc; end
            if (!rst_prev && !wr_start && cur_out !== prev_out) stab_viol++;
        end
        prev_out = cur_out;
        rst_prev = reset;
        if (reset) wbusy = 0;
        else if (wr_start) wbusy = busy_len;
        else if (wbusy > 0) wbusy--;
        wr_ready_w = (wbusy == 0);
        wr_done    = (wbusy == 0);
        if (cyc < NH) done_hist[cyc] = wr_done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        start_cnt = 0; complete_cnt = 0; aborted_cnt = 0; stab_viol = 0;
        cap_idx.delete();
        cap_data.delete();
    endtask

    function automatic logic [4*DW-1:0] exp_row(input logic m, input logic [31:0] s, input int k);
        logic [4*DW-1:0] r;
        logic [31:0] word;
        r = '0;
        for (int w = 0; w < 64; w++) begin
            word = m ? s + 32'(k * 64 + w) : s;
            r[(w / 16) * DW + (w % 16) * 32 +: 32] = word;
        end
        return r;
    endfunction

    // Drain starts the cycle after s; DRAIN counts G cycles, then the first cycle with done leads to finish.
    function automatic int exp_finish(input int s);
        for (int c = s + G + 1; c < NH && c <= cyc; c++) begin
            if (done_hist[c]) return c + 1;
        end
        return -1;
    endfunction

    task automatic issue_cmd(input logic [31:0] f, input logic [15:0] n, input logic m,
                             input logic [31:0] s, output int acc);
        int g;
        cmd_first_row = f; cmd_row_count = n; cmd_mode = m; cmd_seed = s;
        cmd_valid = 1'b1;
        g = 0;
        while (cmd_ready !== 1'b1 && g < 3000) begin tick(); g++; end
        checks++;
        if (g >= 3000) begin failures++; $display("FAIL issue_timeout cmd_ready=%b exp=1", cmd_ready); end
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_finish(input string tag);
        int g;
        g = 0;
        while (complete_cnt + aborted_cnt == 0 && g < 4000) begin tick(); g++; end
        checks++;
        if (g >= 4000) begin failures++; $display("FAIL %s finish_timeout got=none exp=pulse", tag); end
    endtask

    task automatic wait_starts(input int n);
        int g;
        g = 0;
        while (start_cnt < n && g < 3000) begin tick(); g++; end
        checks++;
        if (g >= 3000) begin failures++; $display("FAIL start_timeout got=%0d exp=%0d", start_cnt, n); end
    endtask

    task automatic verify_rows(input string tag, input logic [31:0] f, input logic m,
                               input logic [31:0] s, input int n);
        logic [4*DW-1:0] got, expv;
        checks++;
        if (cap_idx.size() != n) begin
            failures++; $display("FAIL %s row_count got=%0d exp=%0d", tag, cap_idx.size(), n);
        end
        for (int k = 0; k < n && k < cap_idx.size(); k++) begin
            checks++;
            if (cap_idx[k] !== f + 32'(k)) begin
                failures++; $display("FAIL %s row_index k=%0d got=%h exp=%h", tag, k, cap_idx[k], f + 32'(k));
            end
            got = cap_data[k];
            expv = exp_row(m, s, k);
            checks++;
            if (got !== expv) begin
                failures++;
                for (int w = 0; w < 64; w++) begin
                    if (got[w*32 +: 32] !== expv[w*32 +: 32]) begin
                        $display("FAIL %s data k=%0d word=%0d got=%h exp=%h", tag, k, w, got[w*32 +: 32], expv[w*32 +: 32]);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, busy, wr_start, complete, aborted} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=00000", {cmd_ready, busy, wr_start, complete, aborted});
        end
        checks++;
        if (rows_issued !== 16'd0 || cur_out !== '0) begin
            failures++; $display("FAIL reset_data rows=%0d idx=%h exp=0", rows_issued, wr_row_index);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle ready=%b busy=%b exp=1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_const_fill();
        int acc;
        busy_len = 70;
        clear_mon();
        issue_cmd(32'h10, 16'd3, 1'b0, 32'hA5A5A5A5, acc);
        wait_finish("const");
        checks++;
        if (start_cnt != 3 || complete_cnt != 1 || aborted_cnt != 0) begin
            failures++; $display("FAIL const_pulses starts=%0d cpl=%0d abt=%0d exp=3/1/0", start_cnt, complete_cnt, aborted_cnt);
        end
        checks++;
        if (fin_cyc != exp_finish(last_start_cyc)) begin
            failures++; $display("FAIL const_finish_time got=%0d exp=%0d", fin_cyc, exp_finish(last_start_cyc));
        end
        verify_rows("const", 32'h10, 1'b0, 32'hA5A5A5A5, 3);
        repeat (5) tick();
        checks++;
        if (rows_issued !== 16'd3 || busy !== 1'b0) begin
            failures++; $display("FAIL const_hold rows=%0d busy=%b exp=3/0", rows_issued, busy);
        end
    endtask

    task automatic test_incr_wrap();
        int acc;
        logic [4*DW-1:0] r;
        busy_len = 3;
        clear_mon();
        issue_cmd(32'hFFFFFFFF, 16'd2, 1'b1, 32'hFFFFFFC0, acc);
        wait_finish("wrap");
        verify_rows("wrap", 32'hFFFFFFFF, 1'b1, 32'hFFFFFFC0, 2);
        checks++;
        if (cap_data.size() == 2) begin
            r = cap_data[0];
            if (r[31:0] !== 32'hFFFFFFC0 || r[4*DW-1 -: 32] !== 32'hFFFFFFFF) begin
                failures++; $display("FAIL wrap_row0 w0=%h w63=%h exp=ffffffc0/ffffffff", r[31:0], r[4*DW-1 -: 32]);
            end
            r = cap_data[1];
            checks++;
            if (cap_idx[1] !== 32'h0 || r[31:0] !== 32'h0) begin
                failures++; $display("FAIL wrap_row1 idx=%h w0=%h exp=0/0", cap_idx[1], r[31:0]);
            end
        end else begin
            failures++; $display("FAIL wrap_rows got=%0d exp=2", cap_data.size());
        end
    endtask

    task automatic test_stall();
        int acc, r;
        logic [31:0] f, s;
        logic m;
        f = $urandom; s = $urandom; m = 1'($urandom_range(0, 1));
        busy_len = 5;
        stall = 1'b1;
        clear_mon();
        issue_cmd(f, 16'd2, m, s, acc);
        repeat (200) tick();
        checks++;
        if (start_cnt != 0) begin failures++; $display("FAIL stall_nostart got=%0d exp=0", start_cnt); end
        stall = 1'b0;
        r = cyc;
        tick();
        checks++;
        if (start_cnt != 1 || last_start_cyc != r + 1) begin
            failures++; $display("FAIL stall_release start_cyc=%0d exp=%0d", last_start_cyc, r + 1);
        end
        wait_finish("stall");
        verify_rows("stall", f, m, s, 2);
        checks++;
        if (stab_viol != 0) begin failures++; $display("FAIL stall_stability changes=%0d exp=0", stab_viol); end
    endtask

    task automatic test_abort();
        int acc, a;
        busy_len = 30;
        clear_mon();
        issue_cmd(32'h100, 16'd5, 1'b1, 32'h1234_0000, acc);
        wait_starts(2);
        tick();
        abort = 1'b1;
        a = cyc;
        wait_finish("abort_wait");
        abort = 1'b0;
        checks++;
        if (start_cnt != 2 || rows_issued !== 16'd2) begin
            failures++; $display("FAIL abort_rows starts=%0d rows=%0d exp=2/2", start_cnt, rows_issued);
        end
        checks++;
        if (aborted_cnt != 1 || complete_cnt != 0) begin
            failures++; $display("FAIL abort_pulse abt=%0d cpl=%0d exp=1/0", aborted_cnt, complete_cnt);
        end
        checks++;
        if (fin_cyc != exp_finish(a)) begin
            failures++; $display("FAIL abort_finish_time got=%0d exp=%0d", fin_cyc, exp_finish(a));
        end
        verify_rows("abort", 32'h100, 1'b1, 32'h1234_0000, 2);
        busy_len = 4;
        clear_mon();
        issue_cmd(32'h180, 16'd2, 1'b0, 32'h5A5A_0F0F, acc);
        wait_starts(2);
        abort = 1'b1;
        a = last_start_cyc;
        wait_finish("abort_last");
        abort = 1'b0;
        checks++;
        if (aborted_cnt != 1 || complete_cnt != 0 || rows_issued !== 16'd2) begin
            failures++; $display("FAIL abort_last abt=%0d cpl=%0d rows=%0d exp=1/0/2", aborted_cnt, complete_cnt, rows_issued);
        end
        checks++;
        if (fin_cyc != exp_finish(a)) begin
            failures++; $display("FAIL abort_last_time got=%0d exp=%0d", fin_cyc, exp_finish(a));
        end
    endtask

    task automatic test_count_zero();
        int acc;
        clear_mon();
        issue_cmd(32'h55, 16'd0, 1'b0, 32'hDEADBEEF, acc);
        wait_finish("zero");
        checks++;
        if (complete_cnt != 1 || fin_cyc != acc + 1) begin
            failures++; $display("FAIL zero_complete cnt=%0d cyc=%0d exp=1/%0d", complete_cnt, fin_cyc, acc + 1);
        end
        checks++;
        if (start_cnt != 0 || rows_issued !== 16'd0) begin
            failures++; $display("FAIL zero_nostrobe starts=%0d rows=%0d exp=0/0", start_cnt, rows_issued);
        end
    endtask

    task automatic test_busy_hold_and_reset();
        int acc, g;
        busy_len = 10;
        clear_mon();
        issue_cmd(32'h200, 16'd2, 1'b0, 32'h0BAD_F00D, acc);
        cmd_first_row = 32'h300; cmd_row_count = 16'd3; cmd_mode = 1'b1; cmd_seed = 32'h7000_0000;
        cmd_valid = 1'b1;
        g = 0;
        while (cmd_ready !== 1'b1 && g < 3000) begin tick(); g++; end
        checks++;
        if (complete_cnt != 1 || start_cnt != 2) begin
            failures++; $display("FAIL hold_off cpl=%0d starts=%0d exp=1/2", complete_cnt, start_cnt);
        end
        verify_rows("hold_a", 32'h200, 1'b0, 32'h0BAD_F00D, 2);
        clear_mon();
        tick();
        cmd_valid = 1'b0;
        wait_finish("hold_b");
        checks++;
        if (complete_cnt != 1 || rows_issued !== 16'd3) begin
            failures++; $display("FAIL hold_b_done cpl=%0d rows=%0d exp=1/3", complete_cnt, rows_issued);
        end
        verify_rows("hold_b", 32'h300, 1'b1, 32'h7000_0000, 3);

        busy_len = 20;
        clear_mon();
        issue_cmd(32'h400, 16'd3, 1'b1, 32'h0000_1000, acc);
        wait_starts(1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, busy, wr_start, complete, aborted} !== 5'b0 || rows_issued !== 16'd0 || cur_out !== '0) begin
            failures++; $display("FAIL midreset_outputs ctrl=%b rows=%0d idx=%h exp=0", {cmd_ready, busy, wr_start, complete, aborted}, rows_issued, wr_row_index);
        end
        tick();
        reset = 1'b0;
        repeat (30) tick();
        checks++;
        if (complete_cnt != 0 || aborted_cnt != 0 || start_cnt != 1 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_quiet cpl=%0d abt=%0d starts=%0d busy=%b exp=0/0/1/0", complete_cnt, aborted_cnt, start_cnt, busy);
        end
        busy_len = 2;
        clear_mon();
        issue_cmd(32'h500, 16'd2, 1'b0, 32'hCAFE_0001, acc);
        wait_finish("after_reset");
        checks++;
        if (complete_cnt != 1 || rows_issued !== 16'd2) begin
            failures++; $display("FAIL after_reset cpl=%0d rows=%0d exp=1/2", complete_cnt, rows_issued);
        end
        verify_rows("after_reset", 32'h500, 1'b0, 32'hCAFE_0001, 2);
    endtask

    task automatic test_random();
        int acc, n;
        logic [31:0] f, s;
        logic m;
        for (int i = 0; i < 6; i++) begin
            f = $urandom; s = $urandom; m = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 4);
            busy_len = $urandom_range(1, 25);
            clear_mon();
            issue_cmd(f, 16'(n), m, s, acc);
            wait_finish("random");
            checks++;
            if (complete_cnt != 1 || aborted_cnt != 0 || start_cnt != n || rows_issued !== 16'(n)) begin
                failures++; $display("FAIL random_%0d cpl=%0d abt=%0d starts=%0d rows=%0d exp=1/0/%0d/%0d", i, complete_cnt, aborted_cnt, start_cnt, rows_issued, n, n);
            end
            checks++;
            if (fin_cyc != exp_finish(last_start_cyc)) begin
                failures++; $display("FAIL random_time_%0d got=%0d exp=%0d", i, fin_cyc, exp_finish(last_start_cyc));
            end
            verify_rows("random", f, m, s, n);
            checks++;
            if (stab_viol != 0) begin failures++; $display("FAIL random_stability changes=%0d exp=0", stab_viol); end
        end
    endtask

    initial begin
        test_reset();
        test_const_fill();
        test_incr_wrap();
        test_stall();
        test_abort();
        test_count_zero();
        test_busy_hold_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
